// File: rtl/rgb2gray_pkg.sv
// Shared constants and types for the RGB-to-grey streaming converter.
// Fixed-point luma weights are scaled by 2^8 and sum to exactly 256.
package rgb2gray_pkg;

    localparam int LUMA_WR    = 77;
    localparam int LUMA_WG    = 150;
    localparam int LUMA_WB    = 29;
    localparam int LUMA_SHIFT = 8;
    localparam int LUMA_RND   = 1 << (LUMA_SHIFT - 1);

    typedef enum logic {
        MODE_LUMA = 1'b0,
        MODE_MAX  = 1'b1
    } mode_e;

endpackage

// File: rtl/rgb2gray_mac.sv
// Stage-1 product/max registers and the combinational stage-2 sum/round.
// The parent owns all valids; this block only holds data captured on ld_p1.
module rgb2gray_mac
    import rgb2gray_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              ld_p1,
    input  logic [DATA_W-1:0] color_red,
    input  logic [DATA_W-1:0] color_green,
    input  logic [DATA_W-1:0] color_blue,
    input  mode_e             mode,
    output logic [DATA_W-1:0] grey
);

    localparam int PROD_W = DATA_W + 8;
    localparam int ACC_W  = DATA_W + 9;

    logic [PROD_W-1:0] prod_r_p1;
    logic [PROD_W-1:0] prod_g_p1;
    logic [PROD_W-1:0] prod_b_p1;
    logic [DATA_W-1:0] max_p1;
    mode_e             mode_p1;
    logic [ACC_W-1:0]  acc_p1;

    function automatic logic [DATA_W-1:0] max3(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [DATA_W-1:0] c);
        logic [DATA_W-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Round half up, then drop the fractional bits of the 2^8 weight scale.
    function automatic logic [DATA_W-1:0] round_luma(input logic [ACC_W-1:0] acc);
        return DATA_W'((acc + ACC_W'(LUMA_RND)) >> LUMA_SHIFT);
    endfunction

    // Stage 1: weighted products and channel maximum.
    always_ff @(posedge clk) begin
        if (ld_p1) begin
            prod_r_p1 <= PROD_W'(color_red)   * PROD_W'(LUMA_WR);
            prod_g_p1 <= PROD_W'(color_green) * PROD_W'(LUMA_WG);
            prod_b_p1 <= PROD_W'(color_blue)  * PROD_W'(LUMA_WB);
            max_p1    <= max3(color_red, color_green, color_blue);
            mode_p1   <= mode;
        end
    end

    // Stage 2 input: sum and round, selected by the mode captured with the pixel.
    assign acc_p1 = ACC_W'(prod_r_p1) + ACC_W'(prod_g_p1) + ACC_W'(prod_b_p1);
    assign grey   = (mode_p1 == MODE_MAX) ? max_p1 : round_luma(acc_p1);

endmodule

// File: rtl/rgb2gray_stream.sv
// Two-stage valid/ready RGB-to-grey converter with frame last-pixel flagging.
// Optional black/white threshold output enabled by defining RGB2GRAY_THRESH_EN.
module rgb2gray_stream
    import rgb2gray_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int FRAME_PIXELS = 16384
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] color_red,
    input  logic [DATA_W-1:0] color_green,
    input  logic [DATA_W-1:0] color_blue,
    input  logic              mode,
`ifdef RGB2GRAY_THRESH_EN
    input  logic [DATA_W-1:0] thresh,
    input  logic              bw_en,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_grey,
    output logic              out_last
);

    localparam int CNT_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_PIXELS - 1);

    logic              vld_p1;
    logic              vld_p2;
    logic              adv_p2;
    logic              ld_p1;
    logic              ld_p2;
    logic [DATA_W-1:0] mac_grey_p1;
    logic [DATA_W-1:0] grey_next_p1;
    logic [DATA_W-1:0] grey_p2;
    logic [CNT_W-1:0]  pix_cnt;

    // Stage 2 can take new data when empty or when its content leaves this cycle.
    assign adv_p2   = out_ready | ~vld_p2;
    assign ld_p2    = vld_p1 & adv_p2;
    assign in_ready = ~vld_p1 | adv_p2;
    assign ld_p1    = in_valid & in_ready;

    rgb2gray_mac #(
        .DATA_W(DATA_W)
    ) u_mac (
        .clk        (clk),
        .ld_p1      (ld_p1),
        .color_red  (color_red),
        .color_green(color_green),
        .color_blue (color_blue),
        .mode       (mode_e'(mode)),
        .grey       (mac_grey_p1)
    );

`ifdef RGB2GRAY_THRESH_EN
    logic [DATA_W-1:0] thresh_p1;
    logic              bw_en_p1;

    function automatic logic [DATA_W-1:0] apply_thresh(input logic [DATA_W-1:0] g,
                                                       input logic [DATA_W-1:0] t,
                                                       input logic              en);
        if (!en)
            return g;
        return (g >= t) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
    endfunction

    always_ff @(posedge clk) begin
        if (ld_p1) begin
            thresh_p1 <= thresh;
            bw_en_p1  <= bw_en;
        end
    end

    assign grey_next_p1 = apply_thresh(mac_grey_p1, thresh_p1, bw_en_p1);
`else
    assign grey_next_p1 = mac_grey_p1;
`endif

    // Stage 1/2 valids, stage 2 result register and frame pixel counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            grey_p2 <= '0;
            pix_cnt <= '0;
        end else begin
            if (ld_p1)
                vld_p1 <= 1'b1;
            else if (ld_p2)
                vld_p1 <= 1'b0;

            if (ld_p2) begin
                vld_p2  <= 1'b1;
                grey_p2 <= grey_next_p1;
            end else if (out_ready) begin
                vld_p2  <= 1'b0;
            end

            if (vld_p2 && out_ready)
                pix_cnt <= (pix_cnt == CNT_LAST) ? '0 : pix_cnt + CNT_W'(1);
        end
    end

    assign out_valid = vld_p2;
    assign out_grey  = grey_p2;
    assign out_last  = vld_p2 && (pix_cnt == CNT_LAST);

endmodule

// File: tb/tb_rgb2gray_stream.sv
// Directed testbench for rgb2gray_stream with FRAME_PIXELS = 4.
// Threshold scenario is included when RGB2GRAY_THRESH_EN is defined.
module tb_rgb2gray_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] color_red;
    logic [7:0] color_green;
    logic [7:0] color_blue;
    logic       mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_grey;
    logic       out_last;
`ifdef RGB2GRAY_THRESH_EN
    logic [7:0] thresh;
    logic       bw_en;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] gq[$];
    bit         lq[$];

    always #5 clk = ~clk;

    rgb2gray_stream #(
        .DATA_W      (8),
        .FRAME_PIXELS(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .color_red  (color_red),
        .color_green(color_green),
        .color_blue (color_blue),
        .mode       (mode),
`ifdef RGB2GRAY_THRESH_EN
        .thresh     (thresh),
        .bw_en      (bw_en),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_grey   (out_grey),
        .out_last   (out_last)
    );

    // Output transfers happen on the next rising edge; record them mid-cycle.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            gq.push_back(out_grey);
            lq.push_back(out_last);
        end
    end

    task automatic push(input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input logic m);
        bit ok;
        int n;
        in_valid    = 1'b1;
        color_red   = r;
        color_green = g;
        color_blue  = b;
        mode        = m;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: in_ready stayed %0b, required 1", in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        int k;
        k = 0;
        while (gq.size() < n && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (gq.size() != n) begin
            errors++;
            $display("FAIL drain_count: got %0d outputs, required %0d", gq.size(), n);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        gq.delete();
        lq.delete();
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b, required 0", out_valid); end
        checks++;
        if (out_grey !== 8'h00) begin errors++; $display("FAIL rst_out_grey: got %02h, required 00", out_grey); end
        checks++;
        if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %0b, required 0", out_last); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %0b, required 1", in_ready); end
        rst = 1'b0;
        gq.delete();
        lq.delete();
    endtask

    task automatic test_luma();
        logic [7:0] exp_g[4];
        exp_g[0] = 8'hFF;
        exp_g[1] = 8'h4D;
        exp_g[2] = 8'h95;
        exp_g[3] = 8'h53;
        do_reset();
        push(8'hFF, 8'hFF, 8'hFF, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL luma_latency_early: out_valid %0b, required 0", out_valid); end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_grey !== 8'hFF) begin
            errors++;
            $display("FAIL luma_latency: out_valid %0b grey %02h, required 1 FF", out_valid, out_grey);
        end
        push(8'hFF, 8'h00, 8'h00, 1'b0);
        push(8'h00, 8'hFF, 8'h00, 1'b0);
        push(8'h10, 8'h80, 8'h20, 1'b0);
        drain(4);
        for (int i = 0; i < 4 && i < gq.size(); i++) begin
            checks++;
            if (gq[i] !== exp_g[i]) begin errors++; $display("FAIL luma_%0d: got %02h, required %02h", i, gq[i], exp_g[i]); end
        end
    endtask

    task automatic test_max();
        logic [7:0] exp_g[6];
        exp_g[0] = 8'h80;
        exp_g[1] = 8'hFE;
        exp_g[2] = 8'h4D;
        exp_g[3] = 8'hFF;
        exp_g[4] = 8'h95;
        exp_g[5] = 8'hFF;
        do_reset();
        push(8'h10, 8'h80, 8'h20, 1'b1);
        push(8'h01, 8'h02, 8'hFE, 1'b1);
        push(8'hFF, 8'h00, 8'h00, 1'b0);
        push(8'hFF, 8'h00, 8'h00, 1'b1);
        push(8'h00, 8'hFF, 8'h00, 1'b0);
        push(8'h00, 8'hFF, 8'h00, 1'b1);
        drain(6);
        for (int i = 0; i < 6 && i < gq.size(); i++) begin
            checks++;
            if (gq[i] !== exp_g[i]) begin errors++; $display("FAIL max_%0d: got %02h, required %02h", i, gq[i], exp_g[i]); end
        end
    endtask

    task automatic test_back_to_back_stall();
        logic [7:0] held;
        do_reset();
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    logic [7:0] v;
                    v = 8'(8'h10 + i * 8'h11);
                    push(v, v, v, 1'b0);
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                held = 8'(8'h10 + gq.size() * 8'h11);
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    checks++;
                    if (out_valid !== 1'b1 || out_grey !== held) begin
                        errors++;
                        $display("FAIL stall_hold_%0d: valid %0b grey %02h, required 1 %02h", k, out_valid, out_grey, held);
                    end
                end
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %0b, required 0", in_ready); end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain(10);
        for (int i = 0; i < 10 && i < gq.size(); i++) begin
            logic [7:0] e;
            e = 8'(8'h10 + i * 8'h11);
            checks++;
            if (gq[i] !== e) begin errors++; $display("FAIL stall_order_%0d: got %02h, required %02h", i, gq[i], e); end
        end
    endtask

    task automatic test_frame();
        do_reset();
        for (int i = 0; i < 9; i++)
            push(8'(i), 8'(i), 8'(i), 1'b1);
        drain(9);
        for (int i = 0; i < 9 && i < lq.size(); i++) begin
            bit e;
            e = (i % 4) == 3;
            checks++;
            if (lq[i] !== e) begin errors++; $display("FAIL frame_last_%0d: got %0b, required %0b", i, lq[i], e); end
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        push(8'h11, 8'h22, 8'h33, 1'b1);
        drain(1);
        gq.delete();
        lq.delete();
        push(8'hAA, 8'h00, 8'h00, 1'b1);
        push(8'hBB, 8'h00, 8'h00, 1'b1);
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: valid %0b last %0b, required 0 0", out_valid, out_last);
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %0b, required 1", in_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        gq.delete();
        lq.delete();
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (gq.size() != 0) begin errors++; $display("FAIL midrst_stale: got %0d outputs, required 0", gq.size()); end
        for (int i = 0; i < 4; i++)
            push(8'(8'h40 + i), 8'h00, 8'h00, 1'b1);
        drain(4);
        for (int i = 0; i < 4 && i < gq.size(); i++) begin
            bit e;
            e = (i == 3);
            checks++;
            if (gq[i] !== 8'(8'h40 + i) || lq[i] !== e) begin
                errors++;
                $display("FAIL midrst_out_%0d: grey %02h last %0b, required %02h %0b", i, gq[i], lq[i], 8'(8'h40 + i), e);
            end
        end
    endtask

`ifdef RGB2GRAY_THRESH_EN
    task automatic test_thresh();
        logic [7:0] exp_g[3];
        exp_g[0] = 8'hFF;
        exp_g[1] = 8'h00;
        exp_g[2] = 8'h7F;
        do_reset();
        thresh = 8'h80;
        bw_en  = 1'b1;
        push(8'h80, 8'h80, 8'h80, 1'b0);
        push(8'h7F, 8'h7F, 8'h7F, 1'b0);
        bw_en  = 1'b0;
        push(8'h7F, 8'h7F, 8'h7F, 1'b0);
        drain(3);
        for (int i = 0; i < 3 && i < gq.size(); i++) begin
            checks++;
            if (gq[i] !== exp_g[i]) begin errors++; $display("FAIL thresh_%0d: got %02h, required %02h", i, gq[i], exp_g[i]); end
        end
    endtask
`endif

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        color_red   = 8'h00;
        color_green = 8'h00;
        color_blue  = 8'h00;
        mode        = 1'b0;
`ifdef RGB2GRAY_THRESH_EN
        thresh      = 8'h00;
        bw_en       = 1'b0;
`endif
        test_reset();
        test_luma();
        test_max();
        test_back_to_back_stall();
        test_frame();
        test_reset_midframe();
`ifdef RGB2GRAY_THRESH_EN
        test_thresh();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgb2gray_stream.md
RGB2GRAY_STREAM -- requirements
Module: rgb2gray_stream

Interface
REQ-001 Parameter DATA_W, default 8: bits per colour channel and per grey output.
REQ-002 Parameter FRAME_PIXELS, default 16384: pixels per frame, for last-pixel flagging.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, asynchronous and active-high.
REQ-005 Port in_valid  input  1: input pixel present.
REQ-006 Port in_ready  output  1: block accepts the input pixel this cycle.
REQ-007 Port color_red / color_green / color_blue  input  DATA_W each: pixel channels.
REQ-008 Port mode  input  1: 0 = weighted luma, 1 = max(R,G,B); sampled with each pixel.
REQ-009 Port out_valid  output  1: grey pixel present.
REQ-010 Port out_ready  input  1: downstream accepts the output.
REQ-011 Port out_grey  output  DATA_W: grey value.
REQ-012 Port out_last  output  1: output is pixel FRAME_PIXELS-1 of the current frame.

Function
REQ-013 Transfer occurs when valid and ready are both high on the same edge, on either port.
REQ-014 Mode 0: out_grey = (77*R + 150*G + 29*B + 2^7) >> 8, truncated to DATA_W; accumulator width DATA_W+9; weights sum to 256, so no overflow.
REQ-015 Mode 1: out_grey = largest of R, G, B.
REQ-016 Pipeline of 2 registered stages: stage 1 holds products (or the max) plus mode; stage 2 holds the sum/round result.
REQ-017 Latency 2 cycles from input transfer to out_valid when out_ready stays high; throughput 1 pixel/cycle.
REQ-018 A stage loads when it is empty or its content moves on in the same cycle; in_ready = NOT stage-1 valid OR stage 1 advances; no combinational path from in_valid to out_valid.
REQ-019 While out_valid is high and out_ready is low, out_grey/out_last hold stable and no pixel is dropped or duplicated.
REQ-020 The pixel counter (width clog2(FRAME_PIXELS)) increments on each output transfer, wraps from FRAME_PIXELS-1 to 0, and drives out_last = (count == FRAME_PIXELS-1) while out_valid is high.
REQ-021 Mode changes between pixels affect only the pixels sampled with the new mode.
REQ-022 Idle input with stalled output: both stages fill, then in_ready drops low.

Reset
REQ-023 While rst is high: all stage valids = 0, out_valid = 0, out_grey = 0, out_last = 0, pixel counter = 0, in_ready = 1.
REQ-024 Reset asserted mid-frame discards in-flight pixels; after release, the next output is pixel 0 of a new frame.

Configuration
REQ-025 Macro RGB2GRAY_THRESH_EN: when defined, adds input thresh (DATA_W) and input bw_en (1); with bw_en = 1, out_grey = all-ones if grey >= thresh, else 0; both inputs are sampled with the pixel.
REQ-026 Without RGB2GRAY_THRESH_EN: neither port exists, and output is the grey value from REQ-014/015.

Structure
REQ-027 Package rgb2gray_pkg holds the luma weight constants (77/150/29), the rounding constant, the shift amount 8, and the mode enum (MODE_LUMA, MODE_MAX).
REQ-028 Sub-module rgb2gray_mac computes stage-1 products/max and the stage-2 sum; rgb2gray_stream owns the handshake, valids, counter, and threshold.

Verification
REQ-029 Mode 0, R=G=B=0xFF, out_ready=1 -> out_grey=0xFF two cycles after transfer; R=0xFF,G=0,B=0 -> 0x4D; R=0,G=0xFF,B=0 -> 0x95.
REQ-030 Mode 1, (0x10,0x80,0x20) -> 0x80; alternating mode per pixel -> each output matches its own mode.
REQ-031 Stream 10 pixels, out_ready low for 5 cycles mid-stream -> in_ready drops after 2 stalled pixels fill the stages, outputs held stable, all 10 delivered in order.
REQ-032 FRAME_PIXELS=4, 9 pixels -> out_last high on outputs 4 and 8 only, counter wraps.
REQ-033 Reset pulsed with 2 pixels in flight -> out_valid=0 immediately (asynchronous), no stale output after release, next out_last after 4 more pixels (FRAME_PIXELS=4).
REQ-034 With RGB2GRAY_THRESH_EN, thresh=0x80, bw_en=1: grey 0x80 -> 0xFF, grey 0x7F -> 0x00.
